riscv_lsu: RTL and testbench
============================

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 Parameter IW, default 32, data/address width; legal values 32 and 64.
REQ-002 Parameter BE_W, default IW/8, byte-enable width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_req_valid  input  1  core presents a load/store request.
REQ-006 o_req_ready  output  1  LSU accepts a request this cycle.
REQ-007 i_req_wr  input  1  1 = store, 0 = load.
REQ-008 i_req_funct3  input  3  RISC-V size/sign code.
REQ-009 i_req_addr  input  IW  byte address, already rs1+imm.
REQ-010 i_req_wrdata  input  IW  store data, rs2.
REQ-011 i_req_rd  input  5  load destination register tag.
REQ-012 o_rsp_valid, o_rsp_err  output  1 each  response valid / misaligned-or-illegal.
REQ-013 o_rsp_data  output  IW  formatted load data; 0 for stores and errors.
REQ-014 o_rsp_rd  output  5  echoed i_req_rd.
REQ-015 i_rsp_ready  input  1  core consumes response.
REQ-016 o_ldst_addr, o_ldst_wrdata  output  IW each  memory address (aligned down to BE_W) / lane-positioned store data.
REQ-017 o_ldst_rd, o_ldst_wr  output  1 each  memory read/write strobes.
REQ-018 o_ldst_byte_en  output  BE_W  active byte lanes.
REQ-019 i_ldst_rddata  input  IW; i_ldst_waitrequest  input  1.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, RDATA, RESP; o_req_ready = 1 only in IDLE.
REQ-021 Acceptance (valid & ready) SHALL register all request fields; IDLE->REQ, or IDLE->RESP with o_rsp_err=1 if misaligned/illegal.
REQ-022 Misaligned: half addr[0]!=0; word addr[1:0]!=0; dword addr[2:0]!=0; illegal: funct3 3/6 when IW=32, funct3 7, store funct3 >2 (>3 at IW=64); no memory strobe issued.
REQ-023 In REQ, o_ldst_rd or o_ldst_wr SHALL be 1 with address, byte_en, wrdata stable while i_ldst_waitrequest=1.
REQ-024 REQ with waitrequest=0: store->RESP; load->RDATA.
REQ-025 RDATA SHALL capture i_ldst_rddata (valid exactly one cycle after the accepted read), shift right by offset*8, sign- or zero-extend per funct3, ->RESP.
REQ-026 byte_en = size mask (1/3/F/FF) shifted left by addr[log2(BE_W)-1:0]; wrdata = low bytes of rs2 shifted to the same lanes, other lanes 0.
REQ-027 RESP: o_rsp_valid=1, fields held stable until i_rsp_ready=1, then IDLE; new request acceptable the following cycle.
REQ-028 Minimum latency, zero wait: store response 2 cycles after acceptance, load 3, error 1.
REQ-029 Strobes SHALL be 0 in IDLE, RDATA, RESP; never two strobes in one cycle.

Reset
REQ-030 reset low SHALL immediately force IDLE, o_ldst_rd=o_ldst_wr=0, o_rsp_valid=0, o_rsp_err=0, o_rsp_data=0, o_ldst_byte_en=0, o_ldst_addr=0; mid-transaction requests are dropped without response.
REQ-031 o_req_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-032 Funct3 constants (LB..LWU, SB..SD) and the state enum SHALL live in shared package riscv_pkg.
REQ-033 Lane positioning and load extension SHALL be combinational sub-module lsu_align, instantiated once.

Verification
REQ-034 IW=32, sw addr 0x104 data 0xDEADBEEF, no wait -> addr 0x104, byte_en F, wrdata 0xDEADBEEF, rsp_valid 2 cycles after accept, err 0.
REQ-035 IW=32, lb addr 0x203, rddata 0x80FFFFFF -> byte_en 8, rsp_data 0xFFFFFF80; lbu same -> 0x00000080.
REQ-036 lh addr 0x101 -> no strobe, rsp_err 1, rsp_data 0, rsp_valid 1 cycle after accept.
REQ-037 sb addr 0x12 data 0xAB with waitrequest high 3 cycles -> strobe held 4 cycles, byte_en 4, wrdata 0x00AB0000, stable throughout.
REQ-038 IW=64, ld addr 0x8 rddata 0x0123456789ABCDEF -> byte_en FF, rsp_data unchanged; lw addr 0xC -> byte_en F0, data 0x0000000001234567.
REQ-039 Reset asserted while waitrequest high in REQ -> strobes 0 same cycle, no response, o_req_ready 1 after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 size codes, LSU state encoding
// and the request legality check.
package riscv_pkg;

  localparam logic [2:0] LB  = 3'd0, LH  = 3'd1, LW  = 3'd2, LD = 3'd3;
  localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, LWU = 3'd6;
  localparam logic [2:0] SB  = 3'd0, SH  = 3'd1, SW  = 3'd2, SD = 3'd3;

  typedef enum logic [1:0] {IDLE, REQ, RDATA, RESP} lsu_state_e;

  // 1 when the request must be answered with an error and never reach memory
  function automatic logic req_bad(input logic wr, input logic [2:0] f3,
                                   input logic [2:0] a, input logic iw64);
    logic bad;
    bad = (f3 == 3'd7) || (wr && (f3 > (iw64 ? SD : SW))) ||
          (!iw64 && (f3 == LD || f3 == LWU));
    case (f3[1:0])
      2'd1:    bad = bad | a[0];
      2'd2:    bad = bad | (|a[1:0]);
      2'd3:    bad = bad | (|a[2:0]);
      default: ;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core request/response and memory bus bundle of the load/store unit.
interface riscv_lsu_if #(parameter int IW = 32) ();
  localparam int BE_W = IW / 8;

  logic            i_req_valid, o_req_ready, i_req_wr;
  logic [2:0]      i_req_funct3;
  logic [IW-1:0]   i_req_addr, i_req_wrdata;
  logic [4:0]      i_req_rd;
  logic            o_rsp_valid, o_rsp_err, i_rsp_ready;
  logic [IW-1:0]   o_rsp_data;
  logic [4:0]      o_rsp_rd;
  logic [IW-1:0]   o_ldst_addr, o_ldst_wrdata, i_ldst_rddata;
  logic            o_ldst_rd, o_ldst_wr, i_ldst_waitrequest;
  logic [BE_W-1:0] o_ldst_byte_en;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_funct3, i_req_addr, i_req_wrdata, i_req_rd,
           i_rsp_ready, i_ldst_rddata, i_ldst_waitrequest,
    output o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data, o_rsp_rd,
           o_ldst_addr, o_ldst_wrdata, o_ldst_rd, o_ldst_wr, o_ldst_byte_en
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_funct3, i_req_addr, i_req_wrdata, i_req_rd,
           i_rsp_ready, i_ldst_rddata, i_ldst_waitrequest,
    input  o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data, o_rsp_rd,
           o_ldst_addr, o_ldst_wrdata, o_ldst_rd, o_ldst_wr, o_ldst_byte_en
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane positioning of store data / byte enables and load data
// right-justification with sign or zero extension.
module lsu_align import riscv_pkg::*; #(
  parameter int IW   = 32,
  parameter int BE_W = IW / 8,
  localparam int OW  = $clog2(BE_W)
) (
  input  logic [2:0]      funct3_i,
  input  logic [OW-1:0]   off_i,
  input  logic [IW-1:0]   wrdata_i,
  input  logic [IW-1:0]   rddata_i,
  output logic [BE_W-1:0] byte_en_o,
  output logic [IW-1:0]   st_data_o,
  output logic [IW-1:0]   ld_data_o
);
  int            nb;
  logic          sbit;
  logic [IW-1:0] src, sh;

  always_comb begin
    case (funct3_i)
      LB, LBU: nb = 1;
      LH, LHU: nb = 2;
      LW, LWU: nb = 4;
      default: nb = 8;
    endcase
    if (nb > BE_W) nb = BE_W;
    sh   = rddata_i >> {off_i, 3'b000};
    sbit = 1'b0;
    for (int b = 0; b < BE_W; b++)
      if (b == nb - 1) sbit = sh[8*b+7];
    src       = '0;
    ld_data_o = '0;
    byte_en_o = '0;
    for (int b = 0; b < BE_W; b++) begin
      byte_en_o[b]      = (b >= int'(off_i)) && (b < int'(off_i) + nb);
      src[8*b+:8]       = (b < nb) ? wrdata_i[8*b+:8] : 8'h00;
      // funct3[2] marks the unsigned load variants
      ld_data_o[8*b+:8] = (b < nb) ? sh[8*b+:8] : {8{~funct3_i[2] & sbit}};
    end
    st_data_o = src << {off_i, 3'b000};
  end
endmodule

// File: rtl/riscv_lsu.sv
// Single-outstanding load/store unit: accepts one core request, runs one
// memory access (or flags an error) and holds the response until consumed.
module riscv_lsu import riscv_pkg::*; #(
  parameter int IW   = 32,
  parameter int BE_W = IW / 8
) (
  input  logic       clk,
  input  logic       reset,
  riscv_lsu_if.slave bus
);
  localparam int OW = $clog2(BE_W);

  lsu_state_e      state_q;
  logic [2:0]      funct3_q;
  logic [OW-1:0]   off_q;
  logic [4:0]      rd_q;
  logic            ldst_rd_q, ldst_wr_q, rsp_valid_q, rsp_err_q;
  logic [IW-1:0]   ldst_addr_q, ldst_wrdata_q, rsp_data_q;
  logic [BE_W-1:0] be_q;

  logic            idle, bad;
  logic [2:0]      al_f3;
  logic [OW-1:0]   al_off;
  logic [BE_W-1:0] al_be;
  logic [IW-1:0]   al_st, al_ld;

  assign idle = (state_q == IDLE);
  assign bad  = req_bad(bus.i_req_wr, bus.i_req_funct3, bus.i_req_addr[2:0], IW == 64);

  // The aligner serves the incoming request in IDLE and the latched one later
  assign al_f3  = idle ? bus.i_req_funct3 : funct3_q;
  assign al_off = idle ? bus.i_req_addr[OW-1:0] : off_q;

  lsu_align #(.IW(IW), .BE_W(BE_W)) u_align (
    .funct3_i (al_f3),
    .off_i    (al_off),
    .wrdata_i (bus.i_req_wrdata),
    .rddata_i (bus.i_ldst_rddata),
    .byte_en_o(al_be),
    .st_data_o(al_st),
    .ld_data_o(al_ld)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      funct3_q      <= '0;
      off_q         <= '0;
      rd_q          <= '0;
      ldst_rd_q     <= 1'b0;
      ldst_wr_q     <= 1'b0;
      ldst_addr_q   <= '0;
      ldst_wrdata_q <= '0;
      be_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.i_req_valid) begin
          funct3_q <= bus.i_req_funct3;
          off_q    <= bus.i_req_addr[OW-1:0];
          rd_q     <= bus.i_req_rd;
          if (bad) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end else begin
            state_q       <= REQ;
            ldst_rd_q     <= ~bus.i_req_wr;
            ldst_wr_q     <= bus.i_req_wr;
            ldst_addr_q   <= {bus.i_req_addr[IW-1:OW], {OW{1'b0}}};
            ldst_wrdata_q <= bus.i_req_wr ? al_st : '0;
            be_q          <= al_be;
          end
        end
        REQ: if (!bus.i_ldst_waitrequest) begin
          ldst_rd_q <= 1'b0;
          ldst_wr_q <= 1'b0;
          if (ldst_wr_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
          end else begin
            state_q <= RDATA;
          end
        end
        RDATA: begin
          rsp_data_q  <= al_ld;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (bus.i_rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready    = idle;
  assign bus.o_rsp_valid    = rsp_valid_q;
  assign bus.o_rsp_err      = rsp_err_q;
  assign bus.o_rsp_data     = rsp_data_q;
  assign bus.o_rsp_rd       = rd_q;
  assign bus.o_ldst_rd      = ldst_rd_q;
  assign bus.o_ldst_wr      = ldst_wr_q;
  assign bus.o_ldst_addr    = ldst_addr_q;
  assign bus.o_ldst_wrdata  = ldst_wrdata_q;
  assign bus.o_ldst_byte_en = be_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: one 32-bit and one 64-bit instance sharing
// clock and reset, stepped on falling edges with hand-computed expectations.
module tb_riscv_lsu;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  riscv_lsu_if #(.IW(32)) a ();
  riscv_lsu_if #(.IW(64)) b ();

  riscv_lsu #(.IW(32)) u32 (.clk(clk), .reset(reset), .bus(a.slave));
  riscv_lsu #(.IW(64)) u64 (.clk(clk), .reset(reset), .bus(b.slave));

  logic        rdy, rv, er, lrd, lwr;
  logic [4:0]  tag;
  logic [63:0] dat, ad, wd;
  logic [7:0]  be;

  task automatic nclk(); @(negedge clk); endtask

  task automatic chk(input string t, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", t, obs, exp);
    end
  endtask

  task automatic snap(input bit w);
    if (w) begin
      rdy = b.o_req_ready; rv = b.o_rsp_valid; er = b.o_rsp_err; dat = b.o_rsp_data;
      tag = b.o_rsp_rd; lrd = b.o_ldst_rd; lwr = b.o_ldst_wr; ad = b.o_ldst_addr;
      wd = b.o_ldst_wrdata; be = b.o_ldst_byte_en;
    end else begin
      rdy = a.o_req_ready; rv = a.o_rsp_valid; er = a.o_rsp_err; dat = 64'(a.o_rsp_data);
      tag = a.o_rsp_rd; lrd = a.o_ldst_rd; lwr = a.o_ldst_wr; ad = 64'(a.o_ldst_addr);
      wd = 64'(a.o_ldst_wrdata); be = 8'(a.o_ldst_byte_en);
    end
  endtask

  task automatic issue(input bit w, input logic wr, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] data, input logic [4:0] rd);
    if (w) begin
      b.i_req_valid = 1'b1; b.i_req_wr = wr; b.i_req_funct3 = f3;
      b.i_req_addr = addr; b.i_req_wrdata = data; b.i_req_rd = rd;
    end else begin
      a.i_req_valid = 1'b1; a.i_req_wr = wr; a.i_req_funct3 = f3;
      a.i_req_addr = addr[31:0]; a.i_req_wrdata = data[31:0]; a.i_req_rd = rd;
    end
  endtask

  task automatic drop(input bit w);
    if (w) b.i_req_valid = 1'b0; else a.i_req_valid = 1'b0;
  endtask

  task automatic set_mem(input bit w, input logic wt, input logic [63:0] rdat);
    if (w) begin b.i_ldst_waitrequest = wt; b.i_ldst_rddata = rdat; end
    else begin a.i_ldst_waitrequest = wt; a.i_ldst_rddata = rdat[31:0]; end
  endtask

  task automatic finish_rsp(input bit w);
    if (w) b.i_rsp_ready = 1'b1; else a.i_rsp_ready = 1'b1;
    nclk();
    if (w) b.i_rsp_ready = 1'b0; else a.i_rsp_ready = 1'b0;
    snap(w);
    chk("rsp_done", {rv, er, rdy}, 3'b001);
  endtask

  task automatic load(input string t, input bit w, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] rdat, input logic [63:0] exp_ad, input logic [7:0] exp_be,
                      input logic [63:0] exp_d);
    set_mem(w, 1'b0, rdat);
    issue(w, 1'b0, f3, addr, 64'h0, 5'd9);
    nclk(); drop(w); snap(w);
    chk({t, "_strobe"}, {lrd, lwr, rv}, 3'b100);
    chk({t, "_addr"}, ad, exp_ad);
    chk({t, "_be"}, be, exp_be);
    nclk(); snap(w);
    chk({t, "_rdata_st"}, {lrd, lwr, rv}, 3'b000);
    nclk(); snap(w);
    chk({t, "_data"}, dat, exp_d);
    chk({t, "_rsp"}, {rv, er, lrd, lwr, tag}, {4'b1000, 5'd9});
    nclk(); snap(w);
    chk({t, "_hold"}, {rv, dat}, {1'b1, exp_d});
    finish_rsp(w);
  endtask

  task automatic store(input string t, input bit w, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] data, input logic [63:0] exp_ad, input logic [7:0] exp_be,
                       input logic [63:0] exp_wd);
    set_mem(w, 1'b0, 64'h0);
    issue(w, 1'b1, f3, addr, data, 5'd0);
    snap(w);
    chk({t, "_ready"}, rdy, 1'b1);
    nclk(); drop(w); snap(w);
    chk({t, "_strobe"}, {lrd, lwr, rv}, 3'b010);
    chk({t, "_addr"}, ad, exp_ad);
    chk({t, "_be"}, be, exp_be);
    chk({t, "_wd"}, wd, exp_wd);
    nclk(); snap(w);
    chk({t, "_rsp"}, {rv, er, lrd, lwr, dat}, {4'b1000, 64'h0});
    finish_rsp(w);
  endtask

  task automatic bad_req(input string t, input bit w, input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr);
    issue(w, wr, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3);
    nclk(); drop(w); snap(w);
    chk({t, "_err"}, {rv, er, lrd, lwr, rdy}, 5'b11000);
    chk({t, "_data"}, dat, 64'h0);
    finish_rsp(w);
  endtask

  initial begin
    a.i_req_valid = 0; a.i_req_wr = 0; a.i_req_funct3 = 0; a.i_req_addr = 0;
    a.i_req_wrdata = 0; a.i_req_rd = 0; a.i_rsp_ready = 0; a.i_ldst_rddata = 0;
    a.i_ldst_waitrequest = 0;
    b.i_req_valid = 0; b.i_req_wr = 0; b.i_req_funct3 = 0; b.i_req_addr = 0;
    b.i_req_wrdata = 0; b.i_req_rd = 0; b.i_rsp_ready = 0; b.i_ldst_rddata = 0;
    b.i_ldst_waitrequest = 0;

    repeat (2) nclk();
    snap(0);
    chk("rst32", {rv, er, lrd, lwr, be, ad, dat}, '0);
    snap(1);
    chk("rst64", {rv, er, lrd, lwr, be, ad}, '0);
    reset = 1'b1;
    nclk(); snap(0);
    chk("ready_after_rst", {rdy, rv}, 2'b10);

    store("sw", 0, SW, 64'h104, 64'hDEADBEEF, 64'h104, 8'hF, 64'hDEADBEEF);
    load("lb", 0, LB, 64'h203, 64'h80FFFFFF, 64'h200, 8'h8, 64'hFFFFFF80);
    load("lbu", 0, LBU, 64'h203, 64'h80FFFFFF, 64'h200, 8'h8, 64'h00000080);
    load("lh", 0, LH, 64'h102, 64'h8001_7FFF, 64'h100, 8'hC, 64'hFFFF8001);
    bad_req("lh_mis", 0, 1'b0, LH, 64'h101);
    bad_req("sd32", 0, 1'b1, SD, 64'h100);
    bad_req("lw_mis", 0, 1'b0, LW, 64'h102);

    // sb with waitrequest held for three cycles
    set_mem(0, 1'b1, 64'h0);
    issue(0, 1'b1, SB, 64'h12, 64'hAB, 5'd0);
    for (int k = 1; k <= 4; k++) begin
      nclk();
      if (k == 1) drop(0);
      if (k == 4) a.i_ldst_waitrequest = 1'b0;
      snap(0);
      chk("sb_wait", {lrd, lwr, rv, be, ad, wd}, {3'b010, 8'h4, 64'h10, 64'h00AB0000});
    end
    nclk(); snap(0);
    chk("sb_rsp", {rv, er, lrd, lwr}, 4'b1000);
    finish_rsp(0);

    // reset while a load is stalled in REQ
    set_mem(0, 1'b1, 64'h0);
    issue(0, 1'b0, LW, 64'h300, 64'h0, 5'd2);
    nclk(); drop(0); snap(0);
    chk("rst_mid_strobe", {lrd, lwr}, 2'b10);
    #2 reset = 1'b0;
    #1 snap(0);
    chk("rst_mid_async", {lrd, lwr, rv, er, ad}, '0);
    a.i_ldst_waitrequest = 1'b0;
    nclk(); reset = 1'b1;
    nclk(); snap(0);
    chk("rst_mid_ready", {rdy, rv}, 2'b10);
    nclk(); snap(0);
    chk("rst_mid_norsp", {rv, lrd, lwr}, 3'b000);

    load("ld64", 1, LD, 64'h8, 64'h0123456789ABCDEF, 64'h8, 8'hFF, 64'h0123456789ABCDEF);
    load("lw64hi", 1, LW, 64'hC, 64'h0123456789ABCDEF, 64'h8, 8'hF0, 64'h0000000001234567);
    load("lw64lo", 1, LW, 64'h8, 64'h0123456789ABCDEF, 64'h8, 8'h0F, 64'hFFFFFFFF89ABCDEF);
    load("lwu64", 1, LWU, 64'h8, 64'h0123456789ABCDEF, 64'h8, 8'h0F, 64'h0000000089ABCDEF);
    store("sh64", 1, SH, 64'h6, 64'h1234, 64'h0, 8'hC0, 64'h1234000000000000);
    store("sd64", 1, SD, 64'h18, 64'hCAFEF00D12345678, 64'h18, 8'hFF, 64'hCAFEF00D12345678);
    bad_req("ld_mis", 1, 1'b0, LD, 64'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
